// File: rtl/sobel_stream_feeder.sv
// Streams a raster-order RGB frame from a source SRAM into the SobelFilter core
// and writes every 32-bit filter result back to a destination SRAM.
module sobel_stream_feeder #(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int ADDR_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  output logic              o_src_rd,
  output logic [ADDR_W-1:0] o_src_addr,
  input  logic [23:0]       i_src_data,
  output logic              o_rgb_vld,
  output logic [23:0]       o_rgb_data,
  input  logic              i_rgb_busy,
  input  logic              i_result_vld,
  input  logic [31:0]       i_result_data,
  output logic              o_result_busy,
  output logic              o_dst_we,
  output logic [ADDR_W-1:0] o_dst_addr,
  output logic [31:0]       o_dst_data,
  output logic              o_active,
  output logic              o_done
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] N = CNT_W'(IMG_W * IMG_H);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic             start_frame;
  logic [CNT_W-1:0] rd_addr, tx_cnt, rx_cnt;
  logic [23:0]      fifo_mem [2];
  logic             wr_ptr, rd_ptr;
  logic [1:0]       fifo_count, occ_next;
  logic             rd_pending;
  logic             tx_fire, rx_fire;

  always_ff @(posedge i_clk) begin
    if (!i_rst) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    start_frame = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (i_start) begin
          start_frame = 1'b1;
          state_next  = RUN;
        end
      end
      RUN:     if (rx_cnt == N) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  assign o_active      = (state == RUN);
  assign o_done        = (state == DONE);
  assign o_rgb_vld     = (fifo_count != 2'd0) && (tx_cnt < N);
  assign o_rgb_data    = fifo_mem[rd_ptr];
  assign tx_fire       = o_rgb_vld && !i_rgb_busy;
  assign o_result_busy = !((state == RUN) && (rx_cnt < N));
  assign rx_fire       = i_result_vld && !o_result_busy;

  // A pop in this cycle frees its slot immediately, which is what lets the
  // two-entry prefetch sustain one pixel per cycle.
  assign occ_next   = fifo_count + {1'b0, rd_pending} - {1'b0, tx_fire};
  assign o_src_rd   = (state == RUN) && (rd_addr < N) && (occ_next < 2'd2);
  assign o_src_addr = rd_addr[ADDR_W-1:0];

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      rd_addr     <= '0;
      tx_cnt      <= '0;
      rx_cnt      <= '0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_count  <= 2'd0;
      rd_pending  <= 1'b0;
      o_dst_we    <= 1'b0;
      o_dst_addr  <= '0;
      o_dst_data  <= '0;
    end else begin
      o_dst_we <= rx_fire;
      if (rx_fire) begin
        o_dst_addr <= rx_cnt[ADDR_W-1:0];
        o_dst_data <= i_result_data;
      end
      if (start_frame) begin
        rd_addr    <= '0;
        tx_cnt     <= '0;
        rx_cnt     <= '0;
        wr_ptr     <= 1'b0;
        rd_ptr     <= 1'b0;
        fifo_count <= 2'd0;
        rd_pending <= 1'b0;
      end else begin
        rd_pending <= o_src_rd;
        fifo_count <= occ_next;
        if (o_src_rd) rd_addr <= rd_addr + 1'b1;
        // SRAM data is valid exactly one cycle after the read strobe.
        if (rd_pending) begin
          fifo_mem[wr_ptr] <= i_src_data;
          wr_ptr           <= ~wr_ptr;
        end
        if (tx_fire) begin
          rd_ptr <= ~rd_ptr;
          tx_cnt <= tx_cnt + 1'b1;
        end
        if (rx_fire) rx_cnt <= rx_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sobel_stream_feeder.sv
// Bench for sobel_stream_feeder: source/destination SRAMs and an echoing filter
// are modelled here; a frame-level model predicts outputs every cycle.
module tb_sobel_stream_feeder;

  localparam int ADDR_W = 4;
  localparam int N      = 16;

  logic              i_clk, i_rst, i_start;
  logic              o_src_rd;
  logic [ADDR_W-1:0] o_src_addr;
  logic [23:0]       i_src_data;
  logic              o_rgb_vld;
  logic [23:0]       o_rgb_data;
  logic              i_rgb_busy;
  logic              i_result_vld;
  logic [31:0]       i_result_data;
  logic              o_result_busy;
  logic              o_dst_we;
  logic [ADDR_W-1:0] o_dst_addr;
  logic [31:0]       o_dst_data;
  logic              o_active, o_done;

  sobel_stream_feeder #(.IMG_W(4), .IMG_H(4), .ADDR_W(ADDR_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
    .o_src_rd(o_src_rd), .o_src_addr(o_src_addr), .i_src_data(i_src_data),
    .o_rgb_vld(o_rgb_vld), .o_rgb_data(o_rgb_data), .i_rgb_busy(i_rgb_busy),
    .i_result_vld(i_result_vld), .i_result_data(i_result_data),
    .o_result_busy(o_result_busy),
    .o_dst_we(o_dst_we), .o_dst_addr(o_dst_addr), .o_dst_data(o_dst_data),
    .o_active(o_active), .o_done(o_done)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int checks = 0, failures = 0, cyc = 0;
  bit rst_req = 1'b1, start_req = 1'b0;
  int busy_mode = 0, lat_cfg = 1, gap_mode = 0;

  bit m_active = 0, m_done = 0, m_we_exp = 0, m_held = 0;
  int m_rd_next = 0, m_tx = 0, m_rx = 0, m_addr_exp = 0;
  logic [31:0] m_data_exp = '0;
  logic [31:0] fq_data[$];
  int          fq_ready[$];
  logic [31:0] dst_mem [N];
  logic [31:0] dst_ref [N];
  bit rd_latch = 0;
  logic [ADDR_W-1:0] rd_latch_addr = '0;
  bit rst_now = 0, rst_prev = 1, restart_chk = 0, tx_now = 0, rx_now = 0, done_now = 0;
  int first_rd = -1, first_tx = -1, last_tx = -1, start_cyc = 0, frame_writes = 0;

  function automatic logic [23:0] src_val(input int a);
    return 24'(a * 32'h010101);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkOutput();
    if (rst_prev) begin
      chk("rst_src_rd", 32'(o_src_rd), 0);
      chk("rst_rgb_vld", 32'(o_rgb_vld), 0);
      chk("rst_rgb_data", 32'(o_rgb_data), 0);
      chk("rst_result_busy", 32'(o_result_busy), 1);
      chk("rst_dst_we", 32'(o_dst_we), 0);
      chk("rst_dst_addr", 32'(o_dst_addr), 0);
      chk("rst_dst_data", o_dst_data, 0);
      chk("rst_active", 32'(o_active), 0);
      chk("rst_done", 32'(o_done), 0);
    end
    if (restart_chk) begin
      chk("restart_done", 32'(o_done), 0);
      chk("restart_active", 32'(o_active), 1);
    end
    chk("active", 32'(o_active), 32'(m_active));
    chk("done", 32'(o_done), 32'(m_done));
    chk("result_busy", 32'(o_result_busy), 32'(!(m_active && m_rx < N)));
    chk("dst_we", 32'(o_dst_we), 32'(m_we_exp));
    if (m_we_exp) begin
      chk("dst_addr", 32'(o_dst_addr), 32'(m_addr_exp));
      chk("dst_data", o_dst_data, m_data_exp);
    end
    if (m_held) chk("rgb_vld_hold", 32'(o_rgb_vld), 1);
    if (o_rgb_vld) begin
      chk("rgb_vld_in_frame", 32'(m_active && m_tx < N), 1);
      if (m_tx < N) chk("rgb_data", 32'(o_rgb_data), 32'(src_val(m_tx)));
    end
    if (o_src_rd) begin
      chk("src_rd_in_frame", 32'(m_active && m_rd_next < N), 1);
      chk("src_addr", 32'(o_src_addr), 32'(m_rd_next));
      chk("prefetch_depth", 32'((m_rd_next + 1 - (m_tx + int'(tx_now))) <= 2), 1);
    end
  endtask

  // Per-cycle process: drive inputs at the falling edge, compare, then advance
  // the model to what the next rising edge commits.
  initial begin : cycle_proc
    bit gap_ok;
    i_rst = 1'b0; i_start = 1'b0; i_rgb_busy = 1'b0;
    i_result_vld = 1'b0; i_result_data = '0; i_src_data = '0;
    forever begin
      @(negedge i_clk);
      cyc++;
      i_rst     = !rst_req;
      rst_now   = rst_req;
      rst_req   = 1'b0;
      i_start   = start_req;
      start_req = 1'b0;
      i_rgb_busy = (busy_mode == 1) ? (cyc % 3 != 2) : 1'b0;
      i_src_data = rd_latch ? src_val(int'(rd_latch_addr)) : 24'hBAD0BA;
      gap_ok = (gap_mode == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
      if (fq_data.size() > 0 && fq_ready[0] <= cyc && (i_result_vld || gap_ok)) begin
        i_result_vld  = 1'b1;
        i_result_data = fq_data[0];
      end else begin
        i_result_vld  = 1'b0;
        i_result_data = '0;
      end
      #1;
      tx_now = o_rgb_vld && !i_rgb_busy;
      rx_now = i_result_vld && !o_result_busy;
      checkOutput();
      restart_chk   = 1'b0;
      rd_latch      = o_src_rd;
      rd_latch_addr = o_src_addr;
      if (rst_now) begin
        m_active = 0; m_done = 0; m_we_exp = 0; m_held = 0;
        m_rd_next = 0; m_tx = 0; m_rx = 0;
        fq_data.delete(); fq_ready.delete();
        rst_prev = 1'b1;
      end else begin
        rst_prev = 1'b0;
        done_now = m_active && (m_rx == N);
        if (o_dst_we) begin
          dst_mem[o_dst_addr] = o_dst_data;
          frame_writes++;
        end
        if (tx_now) begin
          fq_data.push_back({8'h0, o_rgb_data});
          fq_ready.push_back(cyc + lat_cfg);
          if (first_tx < 0) first_tx = cyc - start_cyc;
          last_tx = cyc - start_cyc;
          m_tx++;
        end
        if (o_src_rd) begin
          if (first_rd < 0) first_rd = cyc - start_cyc;
          m_rd_next++;
        end
        if (rx_now) begin
          m_we_exp   = 1'b1;
          m_addr_exp = m_rx;
          m_data_exp = i_result_data;
          void'(fq_data.pop_front());
          void'(fq_ready.pop_front());
          m_rx++;
        end else begin
          m_we_exp = 1'b0;
        end
        m_held = o_rgb_vld && i_rgb_busy;
        if (!m_active && i_start) begin
          restart_chk = m_done;
          m_active = 1; m_done = 0;
          m_rd_next = 0; m_tx = 0; m_rx = 0;
          start_cyc = cyc; first_rd = -1; first_tx = -1; last_tx = -1;
        end else if (done_now) begin
          m_active = 0;
          m_done   = 1;
        end
      end
    end
  end

  task automatic applyStimulus(input int bmode, input int lat, input int gmode);
    busy_mode = bmode;
    lat_cfg   = lat;
    gap_mode  = gmode;
    for (int a = 0; a < N; a++) dst_mem[a] = 32'hFFFF_FFFF;
    frame_writes = 0;
    @(posedge i_clk);
    start_req = 1'b1;
    @(posedge i_clk);
  endtask

  task automatic waitDone(input int limit);
    int n = 0;
    while (!m_done && n < limit) begin
      @(posedge i_clk);
      n++;
    end
    chk("frame_done", 32'(m_done), 1);
    repeat (2) @(posedge i_clk);
  endtask

  task automatic waitTx(input int k, input int limit);
    int n = 0;
    while (m_tx < k && n < limit) begin
      @(posedge i_clk);
      n++;
    end
    chk("tx_progress", 32'(m_tx >= k), 1);
  endtask

  task automatic checkFrame(input bit timing);
    chk("frame_writes", 32'(frame_writes), 32'(N));
    for (int a = 0; a < N; a++) chk("dst_word", dst_mem[a], {8'h0, src_val(a)});
    if (timing) begin
      chk("first_read_cycle", 32'(first_rd), 1);
      chk("first_tx_cycle", 32'(first_tx), 3);
      chk("tx_span", 32'(last_tx - first_tx), 15);
    end
  endtask

  initial begin : sequencer
    int diffs;
    repeat (3) begin
      @(posedge i_clk);
      rst_req = 1'b1;
    end
    repeat (2) @(posedge i_clk);

    $display("[TB] frame 1: filter never busy, 1-cycle echo");
    applyStimulus(0, 1, 0);
    waitDone(200);
    checkFrame(1'b1);
    for (int a = 0; a < N; a++) dst_ref[a] = dst_mem[a];

    $display("[TB] frame 2: restart from DONE");
    applyStimulus(0, 1, 0);
    waitDone(200);
    checkFrame(1'b1);
    diffs = 0;
    for (int a = 0; a < N; a++) if (dst_mem[a] !== dst_ref[a]) diffs++;
    chk("restart_identical", 32'(diffs), 0);

    $display("[TB] frame 3: rgb busy pattern 1,1,0");
    applyStimulus(1, 1, 0);
    waitDone(300);
    checkFrame(1'b0);

    $display("[TB] frame 4: 3-cycle result latency with gaps");
    applyStimulus(0, 3, 1);
    waitDone(300);
    checkFrame(1'b0);

    $display("[TB] frame 5: start pulsed mid-frame");
    applyStimulus(0, 1, 0);
    waitTx(5, 100);
    start_req = 1'b1;
    waitDone(200);
    checkFrame(1'b0);

    $display("[TB] frame 6: reset after 7 transfers, then restart");
    applyStimulus(1, 2, 0);
    waitTx(7, 100);
    rst_req = 1'b1;
    repeat (3) @(posedge i_clk);
    applyStimulus(0, 1, 0);
    waitDone(200);
    checkFrame(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish (failures so far %0d)", failures);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
